// File: rtl/draw_packet_framer.sv
// Buffers draw-point events in a FIFO and serialises each into a byte packet for the UART path.
// Build option: define DRAW_PACKET_FRAMER_CHECKSUM_EN to insert an XOR checksum byte before the terminator.
module draw_packet_framer #(
  parameter int         DEPTH     = 8,
  parameter int         COL_W     = 8,
  parameter int         ROW_W     = 9,
  parameter int         COLOR_W   = 3,
  parameter logic [7:0] TERM_BYTE = 8'h0A
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [COL_W-1:0]       col_in,
  input  logic [ROW_W-1:0]       row_in,
  input  logic [COLOR_W-1:0]     color_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic                   cts_in,
  output logic [7:0]             tx_data_out,
  output logic                   tx_valid_out,
  input  logic                   tx_ready_in,
  output logic [$clog2(DEPTH):0] fill_out,
  output logic                   overflow_out,
  output logic [15:0]            drop_count_out,
  output logic [15:0]            pkt_count_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int EW = COLOR_W + ROW_W + COL_W;

`ifdef DRAW_PACKET_FRAMER_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [FW-1:0]      fill;
  logic               wr_vld_p1;
  logic [0:0]         state;
  logic [2:0]         idx;
  logic [EW-1:0]      pkt_p1;
  logic               push;
  logic               refuse;
  logic               pop;
  logic               rd_avail;
  logic [COL_W-1:0]   pkt_col;
  logic [ROW_W-1:0]   pkt_row;
  logic [COLOR_W-1:0] pkt_color;
  logic [7:0]         b0;
  logic [7:0]         b1;
  logic [7:0]         b2;
  logic [7:0]         cur_byte;

  assign ready_out    = (fill != FILL_FULL);
  assign push         = valid_in && ready_out;
  assign refuse       = valid_in && !ready_out;
  // The slot written on the previous edge is not yet readable, so the
  // newest entry is excluded from what the reader may pop.
  assign rd_avail     = (fill > {{AW{1'b0}}, wr_vld_p1});
  assign pop          = (state == S_IDLE) && cts_in && rd_avail;
  assign fill_out     = fill;
  assign tx_valid_out = (state == S_SEND);
  assign tx_data_out  = tx_valid_out ? cur_byte : 8'h00;

  assign {pkt_color, pkt_row, pkt_col} = pkt_p1;
  assign b0 = 8'(pkt_col);
  assign b1 = pkt_row[7:0];
  assign b2 = 8'({pkt_color, pkt_row[ROW_W-1:8]});

`ifdef DRAW_PACKET_FRAMER_CHECKSUM_EN
  logic [7:0] ck;
  assign ck = b0 ^ b1 ^ b2;
`endif

  always_comb begin
    cur_byte = TERM_BYTE;
    case (idx)
      3'd0:    cur_byte = b0;
      3'd1:    cur_byte = b1;
      3'd2:    cur_byte = b2;
`ifdef DRAW_PACKET_FRAMER_CHECKSUM_EN
      3'd3:    cur_byte = ck;
`endif
      default: cur_byte = TERM_BYTE;
    endcase
  end

  // Control stage: pointers, occupancy, statistics and the packet sequencer
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill           <= '0;
      wr_vld_p1      <= 1'b0;
      state          <= S_IDLE;
      idx            <= 3'd0;
      overflow_out   <= 1'b0;
      drop_count_out <= 16'd0;
      pkt_count_out  <= 16'd0;
    end else begin
      wr_vld_p1 <= push;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fill <= fill + FILL_ONE;
        2'b01:   fill <= fill - FILL_ONE;
        default: fill <= fill;
      endcase
      if (refuse) begin
        overflow_out   <= 1'b1;
        drop_count_out <= sat_inc16(drop_count_out);
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_SEND;
            idx   <= 3'd0;
          end
        end
        S_SEND: begin
          if (tx_ready_in) begin
            if (idx == LAST_IDX) begin
              state         <= S_IDLE;
              pkt_count_out <= pkt_count_out + 16'd1;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data stage: event storage and the packet register, no reset needed
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= {color_in, row_in, col_in};
    if (pop)  pkt_p1 <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_draw_packet_framer.sv
// Self-checking bench for draw_packet_framer: vector table, directed corner cases and a random run
// scored against a queue-based packet model.
module tb_draw_packet_framer;
  localparam int DEPTH = 8;
`ifdef DRAW_PACKET_FRAMER_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  typedef struct packed {
    logic [2:0] color;
    logic [8:0] row;
    logic [7:0] col;
  } ev_t;

  typedef struct {
    logic [7:0] col;
    logic [8:0] row;
    logic [2:0] color;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] ck;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [7:0]  col_in;
  logic [8:0]  row_in;
  logic [2:0]  color_in;
  logic        valid_in;
  logic        ready_out;
  logic        cts_in;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [3:0]  fill_out;
  logic        overflow_out;
  logic [15:0] drop_count_out;
  logic [15:0] pkt_count_out;

  always #5 clk_in = ~clk_in;

  draw_packet_framer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .col_in(col_in), .row_in(row_in), .color_in(color_in),
    .valid_in(valid_in), .ready_out(ready_out), .cts_in(cts_in),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
    .fill_out(fill_out), .overflow_out(overflow_out),
    .drop_count_out(drop_count_out), .pkt_count_out(pkt_count_out)
  );

  int          total = 0;
  int          bad = 0;
  int          m_fill;
  int          m_bi;
  logic [15:0] m_pkts;
  logic [15:0] m_drops;
  logic        m_ovf;
  ev_t         ev_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  log_q[$];
  vec_t        vec[5];

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_bi = 0; m_pkts = 16'd0; m_drops = 16'd0; m_ovf = 1'b0;
    ev_q.delete(); exp_q.delete(); log_q.delete();
  endtask

  // Packet bytes straight from the format rules
  task automatic load_pkt(input ev_t e);
    logic [7:0] b0, b1, b2;
    b0 = 8'(e.col);
    b1 = e.row[7:0];
    b2 = 8'({e.color, e.row[8]});
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
`ifdef DRAW_PACKET_FRAMER_CHECKSUM_EN
    exp_q.push_back(b0 ^ b1 ^ b2);
`endif
    exp_q.push_back(8'h0A);
  endtask

  // One clock: sample before the edge at negedge, update the model, check after the edge
  task automatic step();
    logic was_v, hs, acc, refd, was_cts;
    logic [7:0] was_d;
    @(negedge clk_in);
    check("ready", 32'(ready_out), 32'(m_fill != DEPTH));
    check("fill", 32'(fill_out), m_fill);
    was_v = tx_valid_out; was_d = tx_data_out; was_cts = cts_in;
    hs   = tx_valid_out && tx_ready_in;
    acc  = valid_in && (m_fill != DEPTH);
    refd = valid_in && (m_fill == DEPTH);
    if (hs) begin
      log_q.push_back(tx_data_out);
      check("byte_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("byte", 32'(tx_data_out), 32'(exp_q.pop_front()));
    end
    @(posedge clk_in);
    #1;
    if (!was_v && tx_valid_out) begin
      check("pop_has_event", 32'(ev_q.size() > 0), 1);
      check("pop_cts", 32'(was_cts), 1);
      if (ev_q.size() > 0) load_pkt(ev_q.pop_front());
      m_fill--;
    end
    if (acc) begin
      ev_q.push_back({color_in, row_in, col_in});
      m_fill++;
    end
    if (refd) begin
      m_ovf = 1'b1;
      if (m_drops != 16'hFFFF) m_drops++;
    end
    if (hs) begin
      m_bi++;
      if (m_bi == NB) begin m_bi = 0; m_pkts++; end
    end
    if (was_v && !hs) begin
      check("hold_valid", 32'(tx_valid_out), 1);
      check("hold_data", 32'(tx_data_out), 32'(was_d));
    end
    check("overflow", 32'(overflow_out), 32'(m_ovf));
    check("drops", 32'(drop_count_out), 32'(m_drops));
    check("pkts", 32'(pkt_count_out), 32'(m_pkts));
  endtask

  task automatic set_ev(input logic [7:0] c, input logic [8:0] r, input logic [2:0] k);
    col_in = c; row_in = r; color_in = k;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int left = budget;
    while (log_q.size() < n && left > 0) begin step(); left--; end
    check("bytes_seen", 32'(log_q.size()), n);
  endtask

  task automatic wait_valid(input int budget);
    int left = budget;
    while (!tx_valid_out && left > 0) begin step(); left--; end
    check("valid_seen", 32'(tx_valid_out), 1);
  endtask

  task automatic drain(input int budget);
    int left = budget;
    valid_in = 1'b0; cts_in = 1'b1; tx_ready_in = 1'b1;
    while (left > 0 && (m_fill != 0 || exp_q.size() != 0 || tx_valid_out)) begin step(); left--; end
    check("drain_left", 32'(m_fill + exp_q.size() + ev_q.size()), 0);
  endtask

  task automatic do_reset();
    valid_in = 1'b0; cts_in = 1'b0; tx_ready_in = 1'b0;
    #2 rst_n_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] want[$];
    vec[0] = '{8'h12, 9'h1A5, 3'd5, 8'h12, 8'hA5, 8'h0B, 8'hBC};
    vec[1] = '{8'h00, 9'h000, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[2] = '{8'hFF, 9'h1FF, 3'd7, 8'hFF, 8'hFF, 8'h0F, 8'h0F};
    vec[3] = '{8'h80, 9'h100, 3'd2, 8'h80, 8'h00, 8'h05, 8'h85};
    vec[4] = '{8'h3C, 9'h0C3, 3'd6, 8'h3C, 8'hC3, 8'h0C, 8'hF3};

    rst_n_in = 1'b1; valid_in = 1'b0; cts_in = 1'b0; tx_ready_in = 1'b0;
    set_ev(8'h00, 9'h000, 3'd0);
    #1 rst_n_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_tx_valid", 32'(tx_valid_out), 0);
    check("rst_tx_data", 32'(tx_data_out), 0);
    check("rst_ready", 32'(ready_out), 1);
    check("rst_fill", 32'(fill_out), 0);
    check("rst_overflow", 32'(overflow_out), 0);
    check("rst_drops", 32'(drop_count_out), 0);
    check("rst_pkts", 32'(pkt_count_out), 0);
    rst_n_in = 1'b1;

    // Vector table: packet formatting and push-to-B0 latency
    for (int i = 0; i < 5; i++) begin
      log_q.delete();
      cts_in = 1'b1; tx_ready_in = 1'b1;
      set_ev(vec[i].col, vec[i].row, vec[i].color);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      check("lat_n0_valid", 32'(tx_valid_out), 0);
      step();
      check("lat_n1_valid", 32'(tx_valid_out), 0);
      step();
      check("lat_n2_valid", 32'(tx_valid_out), 1);
      check("lat_n2_b0", 32'(tx_data_out), 32'(vec[i].b0));
      wait_bytes(NB, 30);
      want.delete();
      want.push_back(vec[i].b0);
      want.push_back(vec[i].b1);
      want.push_back(vec[i].b2);
`ifdef DRAW_PACKET_FRAMER_CHECKSUM_EN
      want.push_back(vec[i].ck);
`endif
      want.push_back(8'h0A);
      for (int j = 0; j < NB; j++)
        if (j < log_q.size()) check("vec_byte", 32'(log_q[j]), 32'(want[j]));
      check("vec_pkts", 32'(pkt_count_out), i + 1);
    end

    // Stall on B1 for 20 cycles
    log_q.delete();
    cts_in = 1'b1; tx_ready_in = 1'b1;
    set_ev(vec[0].col, vec[0].row, vec[0].color);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    wait_valid(10);
    check("stall_b0", 32'(tx_data_out), 32'h12);
    step();
    tx_ready_in = 1'b0;
    check("stall_b1", 32'(tx_data_out), 32'hA5);
    for (int k = 0; k < 20; k++) begin
      step();
      check("stall_valid", 32'(tx_valid_out), 1);
      check("stall_data", 32'(tx_data_out), 32'hA5);
    end
    tx_ready_in = 1'b1;
    step();
    check("stall_b2", 32'(tx_data_out), 32'h0B);
    wait_bytes(NB, 20);

    // cts low: fill the FIFO, overflow by one, then pop while a push is refused
    do_reset();
    cts_in = 1'b0; tx_ready_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_ev(8'($urandom), 9'($urandom), 3'($urandom));
      valid_in = 1'b1;
      step();
      if (i == 7) begin
        check("full_ready", 32'(ready_out), 0);
        check("full_fill", 32'(fill_out), 8);
      end
    end
    valid_in = 1'b0;
    check("ovf_flag", 32'(overflow_out), 1);
    check("ovf_drops", 32'(drop_count_out), 1);
    check("ovf_no_tx", 32'(tx_valid_out), 0);
    cts_in = 1'b1;
    set_ev(8'hEE, 9'h0EE, 3'd1);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    check("popfull_fill", 32'(fill_out), 7);
    check("popfull_drops", 32'(drop_count_out), 2);
    drain(200);
    check("ovf_pkts", 32'(pkt_count_out), 8);

    // Simultaneous push and pop at fill 3
    do_reset();
    cts_in = 1'b0; tx_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ev(8'(i + 1), 9'(i * 37), 3'(i));
      valid_in = 1'b1;
      step();
    end
    check("pp_fill_before", 32'(fill_out), 3);
    cts_in = 1'b1;
    set_ev(8'h44, 9'h144, 3'd4);
    step();
    valid_in = 1'b0;
    check("pp_fill_after", 32'(fill_out), 3);
    check("pp_valid", 32'(tx_valid_out), 1);
    drain(100);
    check("pp_pkts", 32'(pkt_count_out), 4);

    // Asynchronous reset in the middle of B2
    do_reset();
    cts_in = 1'b1; tx_ready_in = 1'b0;
    set_ev(vec[0].col, vec[0].row, vec[0].color);
    valid_in = 1'b1;
    step();
    set_ev(vec[2].col, vec[2].row, vec[2].color);
    step();
    valid_in = 1'b0;
    wait_valid(10);
    tx_ready_in = 1'b1;
    step();
    step();
    tx_ready_in = 1'b0;
    check("prerst_b2", 32'(tx_data_out), 32'h0B);
    check("prerst_fill", 32'(fill_out), 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid_out), 0);
    check("arst_data", 32'(tx_data_out), 0);
    check("arst_fill", 32'(fill_out), 0);
    check("arst_ready", 32'(ready_out), 1);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    cts_in = 1'b1; tx_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    repeat (12) step();
    check("postrst_fill", 32'(fill_out), 0);
    check("postrst_bytes", 32'(log_q.size()), 0);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_ev(8'($urandom), 9'($urandom), 3'($urandom));
      valid_in    = ($urandom_range(0, 99) < 50);
      cts_in      = ($urandom_range(0, 99) < 75);
      tx_ready_in = ($urandom_range(0, 99) < 55);
      step();
    end
    drain(300);
    check("rand_fill", 32'(fill_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
